run_controller: RTL and testbench
=================================

Name: run_controller

Overview:
- Run/debug sequencer for the single-cycle CPU datapath.
- Gates every architectural state update (PC, register file, data memory writes) through one enable.
- Drives the CPU-local reset.
- Decides when the core runs, single-steps or halts on a host command, a PC breakpoint or a halt instruction.
- Sits between the host/testbench command port and the CPU top level; observes the fetched PC and instruction.

Parameters:
- ADDR_W, 32, PC/breakpoint address width.
- INSTR_W, 32, instruction width.
- HALT_INSTR, 32'h0000000C, encoding that halts the core (syscall); it is never executed.
- RST_CYCLES, 4, length of the cpu_rst pulse in cycles (>=1).
- CNT_W, 32, width of cycle_cnt and instr_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_op  in  2  command: 0 RUN, 1 HALT, 2 STEP, 3 CLR.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  ADDR_W  breakpoint PC.
- pc  in  ADDR_W  PC currently presented by the CPU.
- instr  in  INSTR_W  instruction currently fetched.
- cpu_en  out  1  CPU commits the current instruction at this clk edge.
- cpu_rst  out  1  CPU-local reset.
- halted  out  1  state == HALTED.
- halt_cause  out  3  0 NONE, 1 CMD, 2 BREAK, 3 SYSCALL, 4 STEP.
- cycle_cnt  out  CNT_W  cycles spent in RUN/STEP.
- instr_cnt  out  CNT_W  committed instructions.

Behaviour:
- States: CLR, HALTED, RUN, STEP.
- Reset values:
  - state=CLR with the CLR counter loaded to RST_CYCLES-1.
  - cpu_rst=1, cpu_en=0, cmd_ready=0, halted=0, halt_cause=NONE.
  - cycle_cnt=0, instr_cnt=0, skip_bp=0.
- Output timing:
  - cpu_rst = (state==CLR), registered via the state.
  - cmd_ready = (state==HALTED || state==RUN).
  - cpu_en is combinational: (RUN && !stop) || (STEP && !sys).
  - sys = (instr==HALT_INSTR).
  - brk = bp_en && pc==bp_addr && !skip_bp.
  - stop = sys || brk.
- CLR:
  - Lasts exactly RST_CYCLES cycles, then HALTED with cause NONE.
  - cycle_cnt and instr_cnt are cleared on entry.
  - Commands are not accepted.
- HALTED:
  - RUN -> RUN, and sets skip_bp=1.
  - STEP -> STEP.
  - CLR -> CLR.
  - HALT -> no-op; cause is unchanged.
- RUN:
  - skip_bp clears after the first cycle with cpu_en=1. This lets RUN resume from a breakpoint PC without re-trapping.
  - If stop: cpu_en=0 that cycle and next state HALTED. Cause is SYSCALL if sys, else BREAK (sys wins).
  - Accepted HALT: the instruction in the acceptance cycle still commits (if !stop); next state HALTED, cause CMD.
  - Accepted RUN/STEP in RUN: ignored (acknowledged, no effect).
  - Accepted CLR: cpu_en is forced to 0 that cycle; next state CLR.
- Priority in one cycle: CLR cmd > stop > HALT cmd.
- STEP:
  - Exactly one cycle.
  - Commits one instruction unless sys (then cpu_en=0, cause SYSCALL); otherwise cause STEP.
  - Breakpoints are ignored.
  - Always returns to HALTED.
- A halt instruction re-halts on every RUN/STEP. Only CLR (or a PC change by the host) leaves it.
- Counters:
  - cycle_cnt increments every cycle in RUN or STEP, wrapping modulo 2^CNT_W.
  - instr_cnt increments when cpu_en=1, saturating at all-ones.
- rst mid-operation: the next edge forces the reset values regardless of state or pending command. cpu_en drops in the same cycle rst is seen, because cpu_en is qualified by !rst.

Decomposition:
- Shared defines header (with the existing CPU defines) holds: state encodings, cmd_op codes, halt_cause codes, default HALT_INSTR.
- One sub-module: event_counter (parameterised width, clear, increment enable, wrap/saturate select), instantiated twice.

Test Plan:
- Reset release: cpu_rst=1 for exactly 4 cycles after rst deasserts, then halted=1, halt_cause=0, both counters 0.
- RUN with a straight-line 5-instruction program, then syscall at pc=0x14: cpu_en high for 5 cycles and low at pc=0x14; halted=1, halt_cause=3, instr_cnt=5, cycle_cnt=6.
- bp_en=1, bp_addr=0x08, RUN from 0: halts with pc=0x08, cause=2, instr_cnt=2. RUN again: commits 0x08 (cpu_en=1 at pc=0x08) and continues.
- STEP three times from pc=0: exactly one cpu_en pulse per STEP, instr_cnt=3, cause=4 after each; a breakpoint at 0x04 is not honoured.
- HALT during RUN, accepted while pc=0x10: 0x10 commits, halted=1 next cycle, cause=1. CLR plus breakpoint hit in the same cycle: cpu_en=0, next state CLR, counters cleared.
- rst asserted during STEP or CLR: the next cycle shows all reset values and cpu_en=0 in the rst cycle.

Source files
------------

// File: rtl/run_controller_pkg.sv
// Shared definitions for the run/debug sequencer: state encodings, host
// command codes, halt-cause codes and the default halt instruction.
package run_controller_pkg;

  // Sequencer states (legacy-compatible plain constants)
  localparam logic [1:0] ST_CLR    = 2'd0;
  localparam logic [1:0] ST_HALTED = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_STEP   = 2'd3;

  // Host command opcodes carried on cmd_op
  typedef enum logic [1:0] {
    CMD_RUN  = 2'd0,
    CMD_HALT = 2'd1,
    CMD_STEP = 2'd2,
    CMD_CLR  = 2'd3
  } cmd_op_e;

  // Reason the core last stopped, reported on halt_cause
  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_CMD     = 3'd1,
    CAUSE_BREAK   = 3'd2,
    CAUSE_SYSCALL = 3'd3,
    CAUSE_STEP    = 3'd4
  } halt_cause_e;

  // syscall encoding; the core treats it as "stop here" and never executes it
  localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0000_000C;

  // When RUN stops on its own, a halt instruction outranks a breakpoint
  function automatic logic [2:0] stop_cause(input logic sys);
    return sys ? CAUSE_SYSCALL : CAUSE_BREAK;
  endfunction

endpackage

// File: rtl/run_controller_event_counter.sv
// Event counter with synchronous clear and increment enable.
// SATURATE=1 holds at all-ones; SATURATE=0 wraps modulo 2^W.
module run_controller_event_counter #(
  parameter int W        = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear outranks increment; saturation blocks the wrap
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (SATURATE && (&cnt_q)) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Count register with synchronous reset to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/run_controller.sv
// Run/debug sequencer for the single-cycle CPU. A single enable (cpu_en)
// gates every architectural update; the sequencer decides when the core
// runs, single-steps or halts and drives the CPU-local reset.
//
// state  | meaning
// -------+------------------------------------------------------------
// CLR    | CPU held in reset for RST_CYCLES cycles, counters cleared
// HALTED | core frozen, waiting for a host command
// RUN    | core commits one instruction per cycle until a stop/HALT/CLR
// STEP   | one-cycle window committing a single instruction
module run_controller
  import run_controller_pkg::*;
#(
  parameter int                 ADDR_W     = 32,
  parameter int                 INSTR_W    = 32,
  parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(DEFAULT_HALT_INSTR),
  parameter int                 RST_CYCLES = 4,
  parameter int                 CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_op,
  output logic               cmd_ready,
  input  logic               bp_en,
  input  logic [ADDR_W-1:0]  bp_addr,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  output logic               cpu_en,
  output logic               cpu_rst,
  output logic               halted,
  output logic [2:0]         halt_cause,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
);

  // The CLR down-counter runs RST_CYCLES-1 .. 0, so CLR spans RST_CYCLES cycles
  localparam int              RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);

  logic [1:0]      state_q,   state_d;
  logic [RC_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [2:0]      cause_q,   cause_d;
  logic            skip_bp_q, skip_bp_d;

  logic sys;
  logic brk;
  logic stop;
  logic cmd_acc;
  logic clr_acc;
  logic halt_acc;
  logic in_run;
  logic in_step;
  logic cnt_clr;
  logic cyc_inc;

  assign in_run  = (state_q == ST_RUN);
  assign in_step = (state_q == ST_STEP);

  // Stop conditions observed on the fetched instruction / PC. skip_bp lets a
  // RUN resume from the breakpoint PC without immediately re-trapping.
  assign sys  = (instr == HALT_INSTR);
  assign brk  = bp_en && (pc == bp_addr) && !skip_bp_q;
  assign stop = sys || brk;

  // Command handshake: only HALTED and RUN listen to the host
  assign cmd_ready = (state_q == ST_HALTED) || in_run;
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign clr_acc   = cmd_acc && (cmd_op == CMD_CLR);
  assign halt_acc  = cmd_acc && (cmd_op == CMD_HALT);

  // Commit enable. A CLR accepted in RUN suppresses the commit in the same
  // cycle; rst kills it immediately rather than waiting for the next edge.
  always_comb begin
    cpu_en = 1'b0;
    if (!rst) begin
      if (in_run) begin
        cpu_en = !stop && !clr_acc;
      end else if (in_step) begin
        cpu_en = !sys;
      end
    end
  end

  // Next-state logic; inside RUN the priority is CLR command > stop > HALT
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    cause_d   = cause_q;
    skip_bp_d = skip_bp_q && !cpu_en;

    unique case (state_q)
      ST_CLR: begin
        if (clr_cnt_q == '0) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_NONE;
        end else begin
          clr_cnt_d = clr_cnt_q - 1'b1;
        end
      end

      ST_HALTED: begin
        if (cmd_acc) begin
          unique case (cmd_op)
            CMD_RUN: begin
              state_d   = ST_RUN;
              skip_bp_d = 1'b1;
            end
            CMD_STEP: begin
              state_d = ST_STEP;
            end
            CMD_CLR: begin
              state_d   = ST_CLR;
              clr_cnt_d = RC_LOAD;
              cause_d   = CAUSE_NONE;
              skip_bp_d = 1'b0;
            end
            default: begin
              // HALT while already halted: keep the previous cause
            end
          endcase
        end
      end

      ST_RUN: begin
        if (clr_acc) begin
          state_d   = ST_CLR;
          clr_cnt_d = RC_LOAD;
          cause_d   = CAUSE_NONE;
          skip_bp_d = 1'b0;
        end else if (stop) begin
          state_d = ST_HALTED;
          cause_d = stop_cause(sys);
        end else if (halt_acc) begin
          // The instruction in the acceptance cycle has already committed
          state_d = ST_HALTED;
          cause_d = CAUSE_CMD;
        end
      end

      ST_STEP: begin
        state_d = ST_HALTED;
        cause_d = sys ? CAUSE_SYSCALL : CAUSE_STEP;
      end

      default: begin
        state_d = ST_CLR;
        clr_cnt_d = RC_LOAD;
      end
    endcase
  end

  // Sequencer registers; rst overrides any state or pending command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLR;
      clr_cnt_q <= RC_LOAD;
      cause_q   <= CAUSE_NONE;
      skip_bp_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      cause_q   <= cause_d;
      skip_bp_q <= skip_bp_d;
    end
  end

  // Counters are zeroed on the edge that enters CLR and held there during it
  assign cnt_clr = (state_d == ST_CLR);
  assign cyc_inc = in_run || in_step;

  run_controller_event_counter #(
    .W        (CNT_W),
    .SATURATE (1'b0)
  ) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cyc_inc),
    .cnt (cycle_cnt)
  );

  run_controller_event_counter #(
    .W        (CNT_W),
    .SATURATE (1'b1)
  ) u_instr_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cpu_en),
    .cnt (instr_cnt)
  );

  assign cpu_rst    = (state_q == ST_CLR);
  assign halted     = (state_q == ST_HALTED);
  assign halt_cause = cause_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: a tiny PC model advances by 4 on each commit,
// a table of RUN scenarios feeds a scoreboard, and hand sequences cover
// STEP, HALT/CLR commands and rst in the middle of operation.
module tb_run_controller;
  import run_controller_pkg::*;

  localparam logic [31:0] HALT_I = 32'h0000_000C;
  localparam logic [31:0] NOP_I  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic        cmd_ready;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'h0;
  logic [31:0] pc = 32'h0;
  logic [31:0] instr;
  logic [31:0] sys_pc = 32'hFFFF_FFF0;
  logic        cpu_en;
  logic        cpu_rst;
  logic        halted;
  logic [2:0]  halt_cause;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  cause;
    logic [31:0] pc;
    logic [31:0] icnt;
    logic [31:0] ccnt;
  } exp_t;

  typedef struct {
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] sys_pc;
    logic [2:0]  cause;
    logic [31:0] pc;
    logic [31:0] icnt;
    logic [31:0] ccnt;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  // Minimal CPU stand-in: PC resets with cpu_rst and advances on each commit
  always @(posedge clk) begin
    if (cpu_rst) pc <= 32'h0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  assign instr = (pc == sys_pc) ? HALT_I : NOP_I;

  run_controller #(
    .ADDR_W     (32),
    .INSTR_W    (32),
    .HALT_INSTR (HALT_I),
    .RST_CYCLES (4),
    .CNT_W      (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_ready  (cmd_ready),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .instr      (instr),
    .cpu_en     (cpu_en),
    .cpu_rst    (cpu_rst),
    .halted     (halted),
    .halt_cause (halt_cause),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a command at a negedge and hold it until it is taken at a posedge
  task automatic send_cmd(input logic [1:0] op);
    bit acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = cmd_ready;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("cmd_accepted", 32'(acc), 32'd1);
  endtask

  task automatic wait_halted(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic wait_pc(input logic [31:0] target);
    int n = 0;
    while (pc != target && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("reach_pc", pc, target);
  endtask

  task automatic do_clr();
    send_cmd(CMD_CLR);
    wait_halted(20);
  endtask

  task automatic sb_push(input logic [2:0] cause, input logic [31:0] p,
                         input logic [31:0] icnt, input logic [31:0] ccnt);
    exp_t e;
    e.cause = cause; e.pc = p; e.icnt = icnt; e.ccnt = ccnt;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare(input string tag);
    exp_t e;
    check({tag, "_sb_pending"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_cause"},     32'(halt_cause), 32'(e.cause));
      check({tag, "_pc"},        pc,              e.pc);
      check({tag, "_instr_cnt"}, instr_cnt,       e.icnt);
      check({tag, "_cycle_cnt"}, cycle_cnt,       e.ccnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;

    vecs[0] = '{1'b0, 32'h00, 32'h14, 3'd3, 32'h14, 32'd5, 32'd6};
    vecs[1] = '{1'b1, 32'h08, 32'h40, 3'd2, 32'h08, 32'd2, 32'd3};
    vecs[2] = '{1'b1, 32'h00, 32'h0C, 3'd3, 32'h0C, 32'd3, 32'd4};
    vecs[3] = '{1'b1, 32'h0C, 32'h0C, 3'd3, 32'h0C, 32'd3, 32'd4};
    vecs[4] = '{1'b0, 32'h00, 32'h00, 3'd3, 32'h00, 32'd0, 32'd1};
    vecs[5] = '{1'b0, 32'h10, 32'h18, 3'd3, 32'h18, 32'd6, 32'd7};

    // Reset release: exactly four cpu_rst cycles, then halted with clean state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (cpu_rst && n < 20) begin
      check("clr_cmd_ready", 32'(cmd_ready), 32'd0);
      n++;
      @(negedge clk);
    end
    check("reset_clr_len", 32'(n), 32'd4);
    check("reset_halted", 32'(halted), 32'd1);
    check("reset_cause", 32'(halt_cause), 32'd0);
    check("reset_cycle_cnt", cycle_cnt, 32'd0);
    check("reset_instr_cnt", instr_cnt, 32'd0);

    // Table-driven RUN scenarios, each from a freshly cleared core
    for (int i = 0; i < 6; i++) begin
      do_clr();
      bp_en   = vecs[i].bp_en;
      bp_addr = vecs[i].bp_addr;
      sys_pc  = vecs[i].sys_pc;
      sb_push(vecs[i].cause, vecs[i].pc, vecs[i].icnt, vecs[i].ccnt);
      send_cmd(CMD_RUN);
      wait_halted(100);
      sb_compare($sformatf("vec%0d", i));
    end

    // Breakpoint at 0x08, then resume: 0x08 commits on the first RUN cycle
    do_clr();
    bp_en = 1'b1; bp_addr = 32'h08; sys_pc = 32'h40;
    sb_push(3'd2, 32'h08, 32'd2, 32'd3);
    send_cmd(CMD_RUN);
    wait_halted(100);
    sb_compare("bp_first");
    send_cmd(CMD_RUN);
    check("bp_resume_pc", pc, 32'h08);
    check("bp_resume_cpu_en", 32'(cpu_en), 32'd1);
    sb_push(3'd3, 32'h40, 32'd16, 32'd18);
    wait_halted(100);
    sb_compare("bp_resume");

    // Three STEPs from 0 with a breakpoint at 0x04 that must be ignored
    do_clr();
    bp_en = 1'b1; bp_addr = 32'h04; sys_pc = 32'h100;
    for (int k = 0; k < 3; k++) begin
      send_cmd(CMD_STEP);
      pulses = 32'(cpu_en);
      @(negedge clk);
      pulses += 32'(cpu_en);
      check($sformatf("step%0d_pulses", k), 32'(pulses), 32'd1);
      check($sformatf("step%0d_halted", k), 32'(halted), 32'd1);
      check($sformatf("step%0d_cause", k), 32'(halt_cause), 32'd4);
    end
    check("step_instr_cnt", instr_cnt, 32'd3);
    check("step_cycle_cnt", cycle_cnt, 32'd3);
    check("step_pc", pc, 32'h0C);

    // HALT accepted at pc=0x10: that instruction still commits
    do_clr();
    bp_en = 1'b0; sys_pc = 32'h40;
    send_cmd(CMD_RUN);
    wait_pc(32'h10);
    cmd_valid = 1'b1; cmd_op = CMD_HALT;
    #1;
    check("halt_acc_ready", 32'(cmd_ready), 32'd1);
    check("halt_acc_cpu_en", 32'(cpu_en), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("halt_cmd_halted", 32'(halted), 32'd1);
    check("halt_cmd_cause", 32'(halt_cause), 32'd1);
    check("halt_cmd_instr_cnt", instr_cnt, 32'd5);
    check("halt_cmd_cycle_cnt", cycle_cnt, 32'd5);
    check("halt_cmd_pc", pc, 32'h14);

    // CLR in the same cycle as a breakpoint hit: CLR wins
    do_clr();
    bp_en = 1'b1; bp_addr = 32'h0C; sys_pc = 32'h40;
    send_cmd(CMD_RUN);
    wait_pc(32'h0C);
    cmd_valid = 1'b1; cmd_op = CMD_CLR;
    #1;
    check("clr_brk_cpu_en", 32'(cpu_en), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("clr_brk_cpu_rst", 32'(cpu_rst), 32'd1);
    check("clr_brk_halted", 32'(halted), 32'd0);
    check("clr_brk_instr_cnt", instr_cnt, 32'd0);
    check("clr_brk_cycle_cnt", cycle_cnt, 32'd0);
    wait_halted(20);
    check("clr_brk_cause", 32'(halt_cause), 32'd0);
    check("clr_brk_pc", pc, 32'h0);

    // A halt instruction re-halts every RUN and STEP; HALT while halted is a no-op
    do_clr();
    bp_en = 1'b0; sys_pc = 32'h08;
    sb_push(3'd3, 32'h08, 32'd2, 32'd3);
    send_cmd(CMD_RUN);
    wait_halted(100);
    sb_compare("sys_first");
    sb_push(3'd3, 32'h08, 32'd2, 32'd4);
    send_cmd(CMD_RUN);
    wait_halted(20);
    sb_compare("sys_rerun");
    send_cmd(CMD_STEP);
    check("sys_step_cpu_en", 32'(cpu_en), 32'd0);
    @(negedge clk);
    check("sys_step_cause", 32'(halt_cause), 32'd3);
    check("sys_step_instr_cnt", instr_cnt, 32'd2);
    check("sys_step_cycle_cnt", cycle_cnt, 32'd5);
    send_cmd(CMD_HALT);
    check("halt_noop_halted", 32'(halted), 32'd1);
    check("halt_noop_cause", 32'(halt_cause), 32'd3);

    // rst during STEP: commit suppressed in the rst cycle, then reset values
    sys_pc = 32'h100;
    send_cmd(CMD_STEP);
    rst = 1'b1;
    #1;
    check("rst_step_cpu_en", 32'(cpu_en), 32'd0);
    @(negedge clk);
    check("rst_step_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_step_halted", 32'(halted), 32'd0);
    check("rst_step_cause", 32'(halt_cause), 32'd0);
    check("rst_step_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_step_cycle_cnt", cycle_cnt, 32'd0);
    check("rst_step_instr_cnt", instr_cnt, 32'd0);

    // rst in the middle of CLR reloads the full CLR length
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (cpu_rst && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("rst_clr_len", 32'(n), 32'd4);
    check("rst_clr_halted", 32'(halted), 32'd1);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
